// File: rtl/mano_dr_isz_unit_if.sv
// Bus-side signal bundle for the parametrised Mano DR: IR/bus/timing inputs in, DR contents and ISZ status out.
// No valid/ready handshake: every input is sampled on each rising CLK edge and qualified only by the decoded timing step t.
interface mano_dr_isz_unit_if #(
  parameter int WIDTH = 16,
  parameter int TW    = 3
);
  logic [WIDTH-1:0] IN_IR;
  logic [WIDTH-1:0] IN;
  logic [TW-1:0]    t;
  logic             CLR_DR;
  logic [WIDTH-1:0] Q_DR;
  logic             DR_TO_BUS;
  logic             SKIP;
  logic             DR_ZERO;
  logic             WRAP;
  logic             SEQ_ERR;
  logic [1:0]       DBG_STATE;

  modport master (
    output IN_IR, IN, t, CLR_DR,
    input  Q_DR, DR_TO_BUS, SKIP, DR_ZERO, WRAP, SEQ_ERR, DBG_STATE
  );

  modport slave (
    input  IN_IR, IN, t, CLR_DR,
    output Q_DR, DR_TO_BUS, SKIP, DR_ZERO, WRAP, SEQ_ERR, DBG_STATE
  );
endinterface

// File: rtl/mano_dr_isz_unit.sv
// Parametrised Mano DR: decodes opcode/timing, loads and increments DR, and sequences the ISZ
// increment/writeback/skip through a three-state FSM whose state is exported on DBG_STATE.
module mano_dr_isz_unit #(
  parameter int         WIDTH   = 16,
  parameter int         TW      = 3,
  parameter logic [7:0] LD_MASK = 8'b0100_0111,
  parameter logic [2:0] ISZ_OP  = 3'd6,
  parameter int         LD_T    = 4,
  parameter int         INC_T   = 5,
  parameter int         WB_T    = 6
) (
  input  logic                CLK,
  input  logic                RST_N,
  mano_dr_isz_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOADED = 2'd1,
    S_INCED  = 2'd2
  } state_t;

  localparam int TN = 2 ** TW;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_dr;
  logic [WIDTH-1:0] w_dr_nxt;
  logic             r_dr_zero;
  logic             r_wrap;
  logic             w_wrap_nxt;
  logic             r_seq_err;
  logic             w_seq_err_nxt;

  logic [2:0]       w_op;
  logic [TN-1:0]    w_t_hot;
  logic             w_memref;
  logic             w_ld;
  logic             w_inc;
  logic             w_new_instr;
  logic             w_dr_to_bus;
  logic             w_unused;

  assign w_op        = bus.IN_IR[WIDTH-2 -: 3];
  assign w_t_hot     = {{(TN-1){1'b0}}, 1'b1} << bus.t;
  assign w_memref    = (w_op != 3'd7);
  assign w_ld        = w_memref & LD_MASK[w_op] & w_t_hot[LD_T];
  assign w_inc       = w_memref & (w_op == ISZ_OP) & w_t_hot[INC_T];
  assign w_new_instr = (bus.t == '0);

  // The I bit and the address field never gate a DR action.
  assign w_unused = ^{bus.IN_IR[WIDTH-1], bus.IN_IR[WIDTH-5:0], w_t_hot};

  always_comb begin
    w_dr_nxt      = r_dr;
    w_wrap_nxt    = 1'b0;
    w_seq_err_nxt = w_inc & (r_state != S_LOADED);
    if (bus.CLR_DR) begin
      w_dr_nxt = '0;
    end else if (w_ld) begin
      w_dr_nxt = bus.IN;
    end else if (w_inc && (r_state == S_LOADED)) begin
      w_dr_nxt   = r_dr + {{(WIDTH-1){1'b0}}, 1'b1};
      w_wrap_nxt = &r_dr;
    end
  end

  // A clear beside the increment still advances the FSM; a clear beside the load does not.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_ld && (w_op == ISZ_OP) && !bus.CLR_DR) w_state_nxt = S_LOADED;
      S_LOADED: if (w_inc) w_state_nxt = S_INCED;
      S_INCED:  if (w_t_hot[WB_T]) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (w_new_instr) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_dr      <= '0;
      r_dr_zero <= 1'b1;
      r_wrap    <= 1'b0;
      r_seq_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_dr      <= w_dr_nxt;
      r_dr_zero <= (w_dr_nxt == '0);
      r_wrap    <= w_wrap_nxt;
      r_seq_err <= w_seq_err_nxt;
    end
  end

  assign w_dr_to_bus   = (r_state == S_INCED) & w_t_hot[WB_T];
  assign bus.DR_TO_BUS = w_dr_to_bus;
  assign bus.SKIP      = w_dr_to_bus & r_dr_zero;
  assign bus.Q_DR      = r_dr;
  assign bus.DR_ZERO   = r_dr_zero;
  assign bus.WRAP      = r_wrap;
  assign bus.SEQ_ERR   = r_seq_err;
  assign bus.DBG_STATE = r_state;

endmodule

// File: tb/tb_mano_dr_isz_unit.sv
// Self-checking bench for mano_dr_isz_unit: directed vector table, hand-written WIDTH=24 and
// mid-instruction reset sequences, then random stimulus against a behavioural model.
module tb_mano_dr_isz_unit;

  localparam logic [7:0] MASK = 8'b0100_0111;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mano_dr_isz_unit_if #(.WIDTH(16), .TW(3)) if16 ();
  mano_dr_isz_unit_if #(.WIDTH(24), .TW(3)) if24 ();

  mano_dr_isz_unit #(.WIDTH(16)) dut16 (.CLK(clk), .RST_N(rst_n), .bus(if16.slave));
  mano_dr_isz_unit #(.WIDTH(24)) dut24 (.CLK(clk), .RST_N(rst_n), .bus(if24.slave));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive16(input logic [15:0] ir, input logic [15:0] din, input logic [2:0] t,
                         input logic clr);
    if16.IN_IR = ir; if16.IN = din; if16.t = t; if16.CLR_DR = clr;
  endtask

  task automatic drive24(input logic [23:0] ir, input logic [23:0] din, input logic [2:0] t,
                         input logic clr);
    if24.IN_IR = ir; if24.IN = din; if24.t = t; if24.CLR_DR = clr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive16(16'h0, 16'h0, 3'd0, 1'b0);
    drive24(24'h0, 24'h0, 3'd0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [15:0] ir;
    logic [15:0] din;
    logic [2:0]  t;
    logic        clr;
    logic        exp_bus;
    logic        exp_skip;
    logic [15:0] exp_q;
    logic        exp_zero;
    logic        exp_wrap;
    logic        exp_err;
  } vec_t;

  vec_t vecs[24];

  // random-phase model: dr value plus progress through the ISZ instruction
  longint m_dr;
  bit     m_zero;
  bit     m_loaded;
  bit     m_incremented;
  bit     m_wrap;
  bit     m_err;

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b1;
    drive16(16'h0, 16'h0, 3'd0, 1'b0);
    drive24(24'h0, 24'h0, 3'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_q16",    32'(if16.Q_DR), 32'h0);
    check("rst_zero16", 32'(if16.DR_ZERO), 32'h1);
    check("rst_bus16",  32'(if16.DR_TO_BUS), 32'h0);
    check("rst_skip16", 32'(if16.SKIP), 32'h0);
    check("rst_wrap16", 32'(if16.WRAP), 32'h0);
    check("rst_err16",  32'(if16.SEQ_ERR), 32'h0);
    check("rst_q24",    32'(if24.Q_DR), 32'h0);
    check("rst_zero24", 32'(if24.DR_ZERO), 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    //          ir        din       t     clr   bus   skip  q         zero  wrap  err
    vecs[0]  = '{16'h1000, 16'h1234, 3'd4, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'h1000, 16'h0000, 3'd5, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{16'h6000, 16'hFFFF, 3'd0, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{16'h6000, 16'hFFFF, 3'd4, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{16'h6000, 16'hFFFF, 3'd5, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{16'h6000, 16'hFFFF, 3'd6, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{16'h6000, 16'h0005, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{16'h6000, 16'h0005, 3'd4, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{16'h6000, 16'h0005, 3'd5, 1'b0, 1'b0, 1'b0, 16'h0006, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{16'h6000, 16'h0005, 3'd6, 1'b0, 1'b1, 1'b0, 16'h0006, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{16'h6000, 16'h0005, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0006, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{16'h6000, 16'h0005, 3'd4, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{16'h6000, 16'h0005, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{16'h6000, 16'h0005, 3'd5, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{16'h6000, 16'h0005, 3'd6, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{16'h2000, 16'hABCD, 3'd4, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{16'h6000, 16'h0007, 3'd4, 1'b0, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{16'h6000, 16'h0007, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{16'h6000, 16'h0007, 3'd5, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[19] = '{16'h6000, 16'h0007, 3'd6, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[20] = '{16'h7000, 16'h5555, 3'd4, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[21] = '{16'hE000, 16'h00FF, 3'd4, 1'b0, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0};
    vecs[22] = '{16'hE000, 16'h00FF, 3'd5, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    vecs[23] = '{16'h3000, 16'h1111, 3'd4, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive16(vecs[i].ir, vecs[i].din, vecs[i].t, vecs[i].clr);
      #1;
      check($sformatf("vec%0d_bus", i),  32'(if16.DR_TO_BUS), 32'(vecs[i].exp_bus));
      check($sformatf("vec%0d_skip", i), 32'(if16.SKIP), 32'(vecs[i].exp_skip));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_q", i),    32'(if16.Q_DR), 32'(vecs[i].exp_q));
      check($sformatf("vec%0d_zero", i), 32'(if16.DR_ZERO), 32'(vecs[i].exp_zero));
      check($sformatf("vec%0d_wrap", i), 32'(if16.WRAP), 32'(vecs[i].exp_wrap));
      check($sformatf("vec%0d_err", i),  32'(if16.SEQ_ERR), 32'(vecs[i].exp_err));
    end

    // WIDTH=24 ISZ rolling over to zero
    drive16(16'h0, 16'h0, 3'd0, 1'b0);
    @(negedge clk); drive24(24'h600000, 24'hFFFFFF, 3'd0, 1'b0);
    @(negedge clk); drive24(24'h600000, 24'hFFFFFF, 3'd4, 1'b0);
    @(posedge clk); #1;
    check("w24_load_q", 32'(if24.Q_DR), 32'hFFFFFF);
    @(negedge clk); drive24(24'h600000, 24'hFFFFFF, 3'd5, 1'b0);
    @(posedge clk); #1;
    check("w24_inc_q",    32'(if24.Q_DR), 32'h0);
    check("w24_inc_wrap", 32'(if24.WRAP), 32'h1);
    check("w24_inc_zero", 32'(if24.DR_ZERO), 32'h1);
    @(negedge clk); drive24(24'h600000, 24'hFFFFFF, 3'd6, 1'b0);
    #1;
    check("w24_wb_bus",  32'(if24.DR_TO_BUS), 32'h1);
    check("w24_wb_skip", 32'(if24.SKIP), 32'h1);
    @(posedge clk); #1;
    check("w24_wb_wrap", 32'(if24.WRAP), 32'h0);

    // reset dropped mid-ISZ at t=5 aborts the sequence
    @(negedge clk); drive24(24'h600000, 24'hFFFFFF, 3'd0, 1'b0);
    @(negedge clk); drive24(24'h600000, 24'hFFFFFF, 3'd4, 1'b0);
    @(negedge clk); drive24(24'h600000, 24'hFFFFFF, 3'd5, 1'b0);
    @(posedge clk); #1;
    check("rst_mid_pre_wrap", 32'(if24.WRAP), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_q",    32'(if24.Q_DR), 32'h0);
    check("rst_mid_wrap", 32'(if24.WRAP), 32'h0);
    check("rst_mid_err",  32'(if24.SEQ_ERR), 32'h0);
    check("rst_mid_zero", 32'(if24.DR_ZERO), 32'h1);
    check("rst_mid_bus",  32'(if24.DR_TO_BUS), 32'h0);
    @(negedge clk); drive24(24'h600000, 24'hFFFFFF, 3'd6, 1'b0);
    #1;
    check("rst_mid_bus_t6",  32'(if24.DR_TO_BUS), 32'h0);
    check("rst_mid_skip_t6", 32'(if24.SKIP), 32'h0);
    rst_n = 1'b1;
    #1;
    check("rst_after_bus", 32'(if24.DR_TO_BUS), 32'h0);
    check("rst_after_skip", 32'(if24.SKIP), 32'h0);

    // random stimulus against the behavioural model
    do_reset();
    m_dr = 0; m_zero = 1'b1; m_loaded = 1'b0; m_incremented = 1'b0;
    begin
      logic [15:0] ir;
      logic [15:0] din;
      logic [2:0]  t;
      logic        clr;
      int          op;
      bit          ld, inc, exp_bus, exp_skip;
      ir = 16'h6000; t = 3'd0;
      for (int n = 0; n < 400; n++) begin
        if ($urandom_range(0, 3) == 0) ir = 16'($urandom_range(0, 65535));
        if ($urandom_range(0, 7) == 0) ir[14:12] = 3'd6;
        if ($urandom_range(0, 1) == 0) t = 3'($urandom_range(0, 7));
        else t = t + 3'd1;
        din = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
        clr = ($urandom_range(0, 15) == 0);
        op  = int'(ir[14:12]);
        ld  = (op != 7) && MASK[op] && (t == 3'd4);
        inc = (op == 6) && (t == 3'd5);
        exp_bus  = m_incremented && (t == 3'd6);
        exp_skip = exp_bus && m_zero;
        m_wrap = 1'b0;
        m_err  = inc && !(m_loaded && !m_incremented);
        if (clr) m_dr = 0;
        else if (ld) m_dr = longint'(din);
        else if (inc && m_loaded && !m_incremented) begin
          m_wrap = (m_dr == 65535);
          m_dr = (m_dr + 1) % 65536;
        end
        m_zero = (m_dr == 0);
        if (t == 3'd0) begin
          m_loaded = 1'b0; m_incremented = 1'b0;
        end else if (!m_loaded && ld && op == 6 && !clr) begin
          m_loaded = 1'b1;
        end else if (m_loaded && !m_incremented && inc) begin
          m_incremented = 1'b1;
        end else if (m_incremented && t == 3'd6) begin
          m_loaded = 1'b0; m_incremented = 1'b0;
        end
        @(negedge clk);
        drive16(ir, din, t, clr);
        #1;
        check($sformatf("rnd%0d_bus", n),  32'(if16.DR_TO_BUS), 32'(exp_bus));
        check($sformatf("rnd%0d_skip", n), 32'(if16.SKIP), 32'(exp_skip));
        @(posedge clk);
        #1;
        check($sformatf("rnd%0d_q", n),    32'(if16.Q_DR), 32'(m_dr));
        check($sformatf("rnd%0d_zero", n), 32'(if16.DR_ZERO), 32'(m_zero));
        check($sformatf("rnd%0d_wrap", n), 32'(if16.WRAP), 32'(m_wrap));
        check($sformatf("rnd%0d_err", n),  32'(if16.SEQ_ERR), 32'(m_err));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
